trdb_trace_qualifier: RTL and testbench

Parametrised front-end for the trace debugger. It stages retired instructions through next/this/last-cycle phases and filters them by enable and an address range. It accumulates a branch map of configurable depth and emits fixed-format trace records through a FIFO with a valid/ready handshake. Records are lost under backpressure, and those losses are counted and flagged. The block sits between the core trace port and the packet emitter.

---
 rtl/trdb_trace_qualifier.sv | 259 +++++++++++++++++++++++++
 tb/tb_trdb_trace_qualifier.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_trace_qualifier.sv
// Trace qualifier front-end: stages retired instructions (next/this/last), filters them
// by enable and address range, builds a branch map and queues fixed-format trace records.

package trdb_pkg;

  localparam logic [31:0] MASK_BRANCH   = 32'h0000_707f;
  localparam logic [31:0] MATCH_BEQ     = 32'h0000_0063;
  localparam logic [31:0] MATCH_BNE     = 32'h0000_1063;
  localparam logic [31:0] MATCH_PBEQIMM = 32'h0000_2063;
  localparam logic [31:0] MATCH_PBNEIMM = 32'h0000_3063;
  localparam logic [31:0] MATCH_BLT     = 32'h0000_4063;
  localparam logic [31:0] MATCH_BGE     = 32'h0000_5063;
  localparam logic [31:0] MATCH_BLTU    = 32'h0000_6063;
  localparam logic [31:0] MATCH_BGEU    = 32'h0000_7063;

  localparam logic [31:0] MASK_JALR     = 32'h0000_707f;
  localparam logic [31:0] MATCH_JALR    = 32'h0000_0067;
  localparam logic [31:0] MASK_XRET     = 32'hffff_ffff;
  localparam logic [31:0] MATCH_MRET    = 32'h3020_0073;
  localparam logic [31:0] MATCH_SRET    = 32'h1020_0073;
  localparam logic [31:0] MATCH_URET    = 32'h0020_0073;

  typedef enum logic [2:0] {
    KIND_START  = 3'd0,
    KIND_TRAP   = 3'd1,
    KIND_TARGET = 3'd2,
    KIND_PRIV   = 3'd3,
    KIND_FULL   = 3'd4,
    KIND_STOP   = 3'd5
  } rec_kind_e;

  function automatic logic is_branch(input logic [31:0] instr);
    logic [31:0] m;
    m = instr & MASK_BRANCH;
    return (m == MATCH_BEQ)  || (m == MATCH_BNE)  || (m == MATCH_BLT)  || (m == MATCH_BGE) ||
           (m == MATCH_BLTU) || (m == MATCH_BGEU) || (m == MATCH_PBEQIMM) || (m == MATCH_PBNEIMM);
  endfunction

  // Uninferable discontinuities: the target cannot be derived from the program image.
  function automatic logic is_u_disc(input logic [31:0] instr);
    return ((instr & MASK_JALR) == MATCH_JALR) ||
           ((instr & MASK_XRET) == MATCH_MRET) ||
           ((instr & MASK_XRET) == MATCH_SRET) ||
           ((instr & MASK_XRET) == MATCH_URET);
  endfunction

endpackage

module trdb_trace_qualifier
  import trdb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PRIVLEN    = 2,
  parameter int BMAP_LEN   = 31,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                range_en_i,
  input  logic [XLEN-1:0]     range_lo_i,
  input  logic [XLEN-1:0]     range_hi_i,
  input  logic                ivalid_i,
  input  logic                iexception_i,
  input  logic [PRIVLEN-1:0]  priv_i,
  input  logic [XLEN-1:0]     iaddr_i,
  input  logic [31:0]         instr_i,
  input  logic                compressed_i,
  output logic                rec_valid_o,
  input  logic                rec_ready_i,
  output logic [2:0]          rec_kind_o,
  output logic [XLEN-1:0]     rec_iaddr_o,
  output logic [BMAP_LEN-1:0] rec_bmap_o,
  output logic [4:0]          rec_bcnt_o,
  output logic                rec_lost_o,
  output logic [15:0]         overflow_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]    iaddr;
    logic [PRIVLEN-1:0] priv;
    logic               qual;
    logic               exc;
    logic               compressed;
    logic               branch;
    logic               u_disc;
  } instr_t;

  typedef struct packed {
    rec_kind_e           kind;
    logic [XLEN-1:0]     iaddr;
    logic [BMAP_LEN-1:0] bmap;
    logic [4:0]          bcnt;
    logic                lost;
  } rec_t;

  instr_t              nc;
  instr_t              tc_q;
  logic                tc_valid_q;
  logic                lc_valid_q;
  logic                lc_qual_q;
  logic                lc_redirect_q;

  logic [BMAP_LEN-1:0] bmap_q, bmap_upd;
  logic [4:0]          bcnt_q, bcnt_upd;
  logic                lost_q;
  logic [15:0]         ovf_q;

  rec_t                fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;

  logic                in_range;
  logic                resolve;
  logic                taken;
  logic [XLEN-1:0]     seq_addr;
  logic                rec_hit;
  rec_kind_e           kind;
  rec_t                rec_new;
  rec_t                rec_head;
  logic                pop, full, push, drop;

  // ---------------------------------------------------------------------------
  // Capture of the incoming (next-cycle) instruction
  // ---------------------------------------------------------------------------
  assign in_range = !range_en_i || ((range_lo_i <= iaddr_i) && (iaddr_i <= range_hi_i));

  assign nc = '{
    iaddr:      iaddr_i,
    priv:       priv_i,
    qual:       enable_i && in_range,
    exc:        iexception_i,
    compressed: compressed_i,
    branch:     is_branch(instr_i),
    u_disc:     is_u_disc(instr_i)
  };

  // tc is resolved only when its successor shows up.
  assign resolve  = ivalid_i && tc_valid_q;
  assign seq_addr = tc_q.iaddr + (tc_q.compressed ? XLEN'(2) : XLEN'(4));
  assign taken    = (nc.iaddr != seq_addr);

  // ---------------------------------------------------------------------------
  // Branch map update and record selection
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    bmap_upd = bmap_q;
    bcnt_upd = bcnt_q;
    if (tc_q.qual && tc_q.branch) begin
      for (int i = 0; i < BMAP_LEN; i++) begin
        if (bcnt_q == 5'(i)) bmap_upd[i] = taken;
      end
      bcnt_upd = bcnt_q + 5'd1;
    end
  end

  always_comb begin
    rec_hit = 1'b0;
    kind    = KIND_START;
    if (resolve && tc_q.qual) begin
      rec_hit = 1'b1;
      if (!lc_valid_q || !lc_qual_q)        kind = KIND_START;
      else if (tc_q.exc)                    kind = KIND_TRAP;
      else if (lc_redirect_q)               kind = KIND_TARGET;
      else if (tc_q.priv != nc.priv)        kind = KIND_PRIV;
      else if (bcnt_upd == 5'(BMAP_LEN))    kind = KIND_FULL;
      else if (!nc.qual)                    kind = KIND_STOP;
      else                                  rec_hit = 1'b0;
    end
  end

  assign rec_new = '{
    kind:  kind,
    iaddr: tc_q.iaddr,
    bmap:  bmap_upd,
    bcnt:  bcnt_upd,
    lost:  lost_q
  };

  // ---------------------------------------------------------------------------
  // Record FIFO: fullness is judged before this cycle's pop, but a pop frees the slot.
  // ---------------------------------------------------------------------------
  assign pop  = rec_valid_o && rec_ready_i;
  assign full = (count_q == FULL_CNT);
  assign push = rec_hit && (!full || pop);
  assign drop = rec_hit && full && !pop;

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tc_q          <= '0;
      tc_valid_q    <= 1'b0;
      lc_valid_q    <= 1'b0;
      lc_qual_q     <= 1'b0;
      lc_redirect_q <= 1'b0;
      bmap_q        <= '0;
      bcnt_q        <= '0;
      lost_q        <= 1'b0;
      ovf_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      // NOTE: record storage is reset as well, since the outputs read it directly and must be 0.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (ivalid_i) begin
        tc_q       <= nc;
        tc_valid_q <= 1'b1;
        if (tc_valid_q) begin
          lc_valid_q    <= 1'b1;
          lc_qual_q     <= tc_q.qual;
          lc_redirect_q <= tc_q.u_disc || tc_q.exc;
        end
      end

      // An unqualified tc leaves the map untouched; any emitted record restarts it.
      if (resolve && tc_q.qual) begin
        bmap_q <= rec_hit ? '0 : bmap_upd;
        bcnt_q <= rec_hit ? '0 : bcnt_upd;
      end

      if (drop) begin
        lost_q <= 1'b1;
        if (ovf_q != 16'hffff) ovf_q <= ovf_q + 16'd1;
      end else if (push) begin
        lost_q <= 1'b0;
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= rec_new;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers / the head FIFO slot.
  // ---------------------------------------------------------------------------
  assign rec_head       = fifo_q[rd_ptr_q];
  assign rec_valid_o    = (count_q != '0);
  assign rec_kind_o     = rec_head.kind;
  assign rec_iaddr_o    = rec_head.iaddr;
  assign rec_bmap_o     = rec_head.bmap;
  assign rec_bcnt_o     = rec_head.bcnt;
  assign rec_lost_o     = rec_head.lost;
  assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_trdb_trace_qualifier.sv
// Self-checking bench for trdb_trace_qualifier: a list-based reference model checked every
// cycle, plus directed sequences with hand-computed record expectations.

module tb_trdb_trace_qualifier;

  localparam int XLEN       = 32;
  localparam int PRIVLEN    = 2;
  localparam int BMAP_LEN   = 4;
  localparam int FIFO_DEPTH = 2;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] MRET = 32'h3020_0073;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                enable_i = 1'b1;
  logic                range_en_i = 1'b0;
  logic [XLEN-1:0]     range_lo_i = '0;
  logic [XLEN-1:0]     range_hi_i = '0;
  logic                ivalid_i = 1'b0;
  logic                iexception_i = 1'b0;
  logic [PRIVLEN-1:0]  priv_i = 2'd3;
  logic [XLEN-1:0]     iaddr_i = '0;
  logic [31:0]         instr_i = NOP;
  logic                compressed_i = 1'b0;
  logic                rec_ready_i = 1'b1;
  logic                rec_valid_o;
  logic [2:0]          rec_kind_o;
  logic [XLEN-1:0]     rec_iaddr_o;
  logic [BMAP_LEN-1:0] rec_bmap_o;
  logic [4:0]          rec_bcnt_o;
  logic                rec_lost_o;
  logic [15:0]         overflow_cnt_o;

  trdb_trace_qualifier #(
    .XLEN(XLEN), .PRIVLEN(PRIVLEN), .BMAP_LEN(BMAP_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .range_en_i(range_en_i),
    .range_lo_i(range_lo_i), .range_hi_i(range_hi_i), .ivalid_i(ivalid_i),
    .iexception_i(iexception_i), .priv_i(priv_i), .iaddr_i(iaddr_i), .instr_i(instr_i),
    .compressed_i(compressed_i), .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_kind_o(rec_kind_o), .rec_iaddr_o(rec_iaddr_o), .rec_bmap_o(rec_bmap_o),
    .rec_bcnt_o(rec_bcnt_o), .rec_lost_o(rec_lost_o), .overflow_cnt_o(overflow_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: instruction history, branch outcome list, record queue.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  priv;
    bit          qual;
    bit          exc;
    bit          comp;
    bit          br;
    bit          disc;
  } ins_t;

  typedef struct {
    int                  kind;
    logic [31:0]         addr;
    logic [BMAP_LEN-1:0] bmap;
    int                  bcnt;
    bit                  lost;
  } rec_t;

  ins_t hist[$];
  bit   bits[$];
  rec_t exp_q[$];
  rec_t got[$];
  int   m_ovf = 0;
  bit   m_lost = 1'b0;

  always @(posedge clk) begin : model
    ins_t nc, tc, lc;
    rec_t r;
    bit   pop, was_full, has_lc;
    int   kind;
    if (rec_valid_o === 1'b1 && rec_ready_i) begin
      r.kind = int'(rec_kind_o); r.addr = rec_iaddr_o; r.bmap = rec_bmap_o;
      r.bcnt = int'(rec_bcnt_o); r.lost = rec_lost_o;
      got.push_back(r);
    end
    if (rst_i) begin
      hist.delete(); bits.delete(); exp_q.delete(); got.delete();
      m_ovf = 0; m_lost = 1'b0;
    end else begin
      was_full = (exp_q.size() == FIFO_DEPTH);
      pop = (exp_q.size() != 0) && rec_ready_i;
      if (pop) void'(exp_q.pop_front());
      if (ivalid_i) begin
        nc.addr = iaddr_i;
        nc.priv = priv_i;
        nc.qual = enable_i && (!range_en_i || (iaddr_i >= range_lo_i && iaddr_i <= range_hi_i));
        nc.exc  = iexception_i;
        nc.comp = compressed_i;
        nc.br   = (instr_i[6:0] == 7'h63);
        nc.disc = (instr_i[6:0] == 7'h67 && instr_i[14:12] == 3'd0) ||
                  instr_i == 32'h3020_0073 || instr_i == 32'h1020_0073 || instr_i == 32'h0020_0073;
        if (hist.size() != 0) begin
          tc = hist[hist.size()-1];
          has_lc = hist.size() > 1;
          if (has_lc) lc = hist[hist.size()-2];
          if (tc.qual) begin
            if (tc.br) bits.push_back(nc.addr != tc.addr + (tc.comp ? 32'd2 : 32'd4));
            kind = -1;
            if (!has_lc || !lc.qual)            kind = 0;
            else if (tc.exc)                    kind = 1;
            else if (lc.disc || lc.exc)         kind = 2;
            else if (tc.priv != nc.priv)        kind = 3;
            else if (bits.size() == BMAP_LEN)   kind = 4;
            else if (!nc.qual)                  kind = 5;
            if (kind >= 0) begin
              r.kind = kind; r.addr = tc.addr; r.bmap = '0;
              foreach (bits[i]) r.bmap[i] = bits[i];
              r.bcnt = bits.size();
              bits.delete();
              if (was_full && !pop) begin
                if (m_ovf < 65535) m_ovf++;
                m_lost = 1'b1;
              end else begin
                r.lost = m_lost;
                m_lost = 1'b0;
                exp_q.push_back(r);
              end
            end
          end
        end
        hist.push_back(nc);
        if (hist.size() > 2) void'(hist.pop_front());
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("valid", rec_valid_o, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("kind",  rec_kind_o,  exp_q[0].kind);
        check("iaddr", rec_iaddr_o, exp_q[0].addr);
        check("bmap",  rec_bmap_o,  exp_q[0].bmap);
        check("bcnt",  rec_bcnt_o,  exp_q[0].bcnt);
        check("lost",  rec_lost_o,  exp_q[0].lost);
      end
      check("overflow", overflow_cnt_o, m_ovf);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input logic [31:0] addr, input logic [31:0] word,
                     input bit exc = 1'b0, input bit comp = 1'b0, input logic [1:0] priv = 2'd3);
    @(negedge clk); #1;
    ivalid_i = 1'b1; iaddr_i = addr; instr_i = word;
    iexception_i = exc; compressed_i = comp; priv_i = priv;
    @(posedge clk); #1;
    ivalid_i = 1'b0; iexception_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    enable_i = 1'b1; range_en_i = 1'b0; rec_ready_i = 1'b1; priv_i = 2'd3;
  endtask

  task automatic expect_rec(input int idx, input int kind, input logic [31:0] addr,
                            input logic [BMAP_LEN-1:0] bmap, input int bcnt, input bit lost,
                            input string tag);
    if (idx < got.size()) begin
      check({tag, "_kind"},  got[idx].kind, kind);
      check({tag, "_iaddr"}, got[idx].addr, addr);
      check({tag, "_bmap"},  got[idx].bmap, bmap);
      check({tag, "_bcnt"},  got[idx].bcnt, bcnt);
      check({tag, "_lost"},  got[idx].lost, lost);
    end else begin
      check({tag, "_present"}, got.size(), idx + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, rec_valid_o, 0);
    check({tag, "_kind"},  rec_kind_o, 0);
    check({tag, "_iaddr"}, rec_iaddr_o, 0);
    check({tag, "_bmap"},  rec_bmap_o, 0);
    check({tag, "_bcnt"},  rec_bcnt_o, 0);
    check({tag, "_lost"},  rec_lost_o, 0);
    check({tag, "_ovf"},   overflow_cnt_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk); #1 run_cmp = 1'b1;
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1 rst_i = 1'b0;

    // Straight-line code: single START, visible one cycle after 0x104
    do_reset();
    cyc(32'h100, NOP); cyc(32'h104, NOP);
    @(negedge clk);
    check("t1_valid_latency", rec_valid_o, 1);
    cyc(32'h108, NOP); cyc(32'h10C, NOP);
    idle(4);
    check("t1_count", got.size(), 1);
    expect_rec(0, 0, 32'h100, 4'b0000, 0, 1'b0, "t1_start");

    // Branch map fills to BMAP_LEN = 4
    do_reset();
    cyc(32'h100, NOP); cyc(32'h200, BEQ); cyc(32'h300, BEQ);
    cyc(32'h304, BEQ); cyc(32'h400, BEQ); cyc(32'h404, NOP);
    enable_i = 1'b0; cyc(32'h408, NOP); enable_i = 1'b1;
    idle(4);
    check("t2_count", got.size(), 3);
    expect_rec(0, 0, 32'h100, 4'b0000, 0, 1'b0, "t2_start");
    expect_rec(1, 4, 32'h400, 4'b0101, 4, 1'b0, "t2_full");
    expect_rec(2, 5, 32'h404, 4'b0000, 0, 1'b0, "t2_stop");

    // Address range filter with inclusive bounds
    do_reset();
    range_en_i = 1'b1; range_lo_i = 32'h200; range_hi_i = 32'h2FF;
    cyc(32'h1FC, NOP); cyc(32'h200, NOP); cyc(32'h204, NOP); cyc(32'h300, NOP);
    idle(4);
    check("t3_count", got.size(), 2);
    expect_rec(0, 0, 32'h200, 4'b0000, 0, 1'b0, "t3_start");
    expect_rec(1, 5, 32'h204, 4'b0000, 0, 1'b0, "t3_stop");

    // Backpressure: third record dropped, lost flag on the next accepted record only
    do_reset();
    rec_ready_i = 1'b0;
    cyc(32'h100, NOP, 0, 0, 2'd3); cyc(32'h104, NOP, 0, 0, 2'd0);
    cyc(32'h108, NOP, 0, 0, 2'd3); cyc(32'h10C, NOP, 0, 0, 2'd0);
    @(negedge clk);
    check("t4_overflow", overflow_cnt_o, 1);
    check("t4_held_valid", rec_valid_o, 1);
    #1 rec_ready_i = 1'b1;
    for (int i = 0; i < 16 && rec_valid_o; i++) @(negedge clk);
    check("t4_drained", rec_valid_o, 0);
    cyc(32'h110, NOP, 0, 0, 2'd3); cyc(32'h114, NOP, 0, 0, 2'd0);
    idle(4);
    check("t4_count", got.size(), 4);
    expect_rec(0, 0, 32'h100, 4'b0000, 0, 1'b0, "t4_r0");
    expect_rec(1, 3, 32'h104, 4'b0000, 0, 1'b0, "t4_r1");
    expect_rec(2, 3, 32'h10C, 4'b0000, 0, 1'b1, "t4_r2");
    expect_rec(3, 3, 32'h110, 4'b0000, 0, 1'b0, "t4_r3");
    check("t4_overflow_end", overflow_cnt_o, 1);

    // Trap, trap target, jalr and mret targets
    do_reset();
    cyc(32'h11C, NOP); cyc(32'h120, NOP, 1'b1); cyc(32'h8, NOP); cyc(32'hC, NOP);
    cyc(32'h130, JALR); cyc(32'h500, NOP); cyc(32'h504, MRET); cyc(32'h600, NOP);
    cyc(32'h604, NOP);
    idle(4);
    check("t5_count", got.size(), 5);
    expect_rec(0, 0, 32'h11C, 4'b0000, 0, 1'b0, "t5_start");
    expect_rec(1, 1, 32'h120, 4'b0000, 0, 1'b0, "t5_trap");
    expect_rec(2, 2, 32'h008, 4'b0000, 0, 1'b0, "t5_target_trap");
    expect_rec(3, 2, 32'h500, 4'b0000, 0, 1'b0, "t5_target_jalr");
    expect_rec(4, 2, 32'h600, 4'b0000, 0, 1'b0, "t5_target_mret");

    // Compressed branches advance by 2
    do_reset();
    cyc(32'h100, NOP); cyc(32'h102, BEQ, 0, 1'b1); cyc(32'h104, BEQ, 0, 1'b1);
    enable_i = 1'b0; cyc(32'h200, NOP); enable_i = 1'b1;
    idle(4);
    check("t6_count", got.size(), 2);
    expect_rec(1, 5, 32'h104, 4'b0010, 2, 1'b0, "t6_stop");

    // Reset with two queued records and a partial branch map
    do_reset();
    rec_ready_i = 1'b0;
    cyc(32'h100, NOP, 0, 0, 2'd3); cyc(32'h104, NOP, 0, 0, 2'd3);
    cyc(32'h108, BEQ, 0, 0, 2'd0); cyc(32'h200, BEQ, 0, 0, 2'd0);
    cyc(32'h204, BEQ, 0, 0, 2'd0); cyc(32'h300, NOP, 0, 0, 2'd0);
    @(negedge clk);
    check("t7_queued_valid", rec_valid_o, 1);
    #1 rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check_all_zero("t7_rst");
    #1 rec_ready_i = 1'b1;
    cyc(32'h900, NOP); cyc(32'h904, NOP);
    idle(4);
    check("t7_count", got.size(), 1);
    expect_rec(0, 0, 32'h900, 4'b0000, 0, 1'b0, "t7_start");

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
